tone_arbiter: RTL and testbench
===============================

# tone_arbiter

Shares the single speaker pin among several tone players (click, invalid-move, winner) in the Tic Tac Toe PS2-mouse design. Game logic raises per-source play requests. The arbiter latches them, grants one source at a time by fixed priority, and fires that player's trigger. It routes the granted player's square wave to the speaker, enforces a maximum play time, and inserts a silent gap between tones.

## Interface
- `CLOCK_FREQUENCY`, 50000000, clock rate in Hz.
- `NUM_SOURCES`, 3, number of tone players; index 0 has the highest priority.
- `MAX_MS`, 3000, maximum grant duration in ms before forced release.
- `GAP_MS`, 20, silence between consecutive tones in ms.
- `clock`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `mute`  in  1  forces `sound` low; does not affect arbitration.
- `req`  in  NUM_SOURCES  play request per source, level or pulse; the rising edge is captured.
- `player_busy`  in  NUM_SOURCES  high while the corresponding player is sounding.
- `player_sound`  in  NUM_SOURCES  square-wave outputs of the players.
- `trigger`  out  NUM_SOURCES  one-cycle active-high start pulse to the granted player.
- `player_enable`  out  NUM_SOURCES  one-hot enable; only the granted player runs.
- `grant`  out  $clog2(NUM_SOURCES)  index of the current or last grant.
- `active`  out  1  high from START through PLAY.
- `sound`  out  1  speaker drive.

## Operation
- Pending register `pend[NUM_SOURCES]`:
  - Set on a rising edge of `req[i]`, detected against a registered copy of `req`.
  - Cleared when source i enters START.
  - Set and clear in the same cycle: set wins if the edge belongs to a new request arriving during START. A repeated request is never lost; at most one is queued per source.
- State machine (state constants in the package):
  - IDLE: if any `pend` bit is set, `grant` <= lowest set index, go to START.
  - START: `trigger[grant]`=1 for exactly this cycle; clear `pend[grant]`; go to WAIT.
  - WAIT: wait for `player_busy[grant]`=1, which accommodates the player's ROM latency. If it arrives within 8 cycles, go to PLAY; otherwise go to GAP (dead player).
  - PLAY: go to GAP when `player_busy[grant]`=0 or the timer reaches MAX_MS·(CLOCK_FREQUENCY/1000)−1.
  - GAP: silence for GAP_MS·(CLOCK_FREQUENCY/1000) cycles, then IDLE.
- No preemption. A higher-priority request arriving during PLAY waits in `pend`.
- `player_enable` is one-hot on `grant` in START, WAIT and PLAY, and all-zero otherwise. The timeout therefore stops the player.
- `sound` = `player_sound[grant]` & `active` & ~`mute`, registered.
- Timer: a single 32-bit counter, cleared on every state entry; it compares against constants computed at elaboration.

## Timing
- Reset values: state IDLE, `pend`=0, `trigger`=0, `player_enable`=0, `grant`=0, `active`=0, `sound`=0, timer=0.
- Latency with the arbiter idle and `req[i]` rising at edge k:
  - Pending set at k+1.
  - START, with `trigger[i]`=1, at k+2.
  - `sound` follows `player_sound` with one cycle of delay.
- `active` is high in START, WAIT and PLAY.
- Simultaneous requests: the lowest index is granted; the others are served in ascending index order after each GAP.
- Timeout boundary: PLAY lasts exactly MAX_MS·CLOCK_FREQUENCY/1000 cycles when busy stays high.
- Reset mid-operation: all state returns to reset values on the next edge and pending requests are discarded.
- `mute` toggling mid-tone affects only `sound`.

## Structure
- Package `tone_arbiter_pkg`: state encodings (IDLE, START, WAIT, PLAY, GAP), the WAIT limit of 8, and the timer width of 32.
- Sub-module `tone_priority_encoder`: combinational lowest-index-first encoder, NUM_SOURCES → index plus a valid bit.
- Players (`winnerTone`-style) stay external; the arbiter only drives their trigger and enable. Where a player uses an active-low trigger, the inversion is done at the instantiation site.

## Test plan
All scenarios use CLOCK_FREQUENCY=1000, so 1 cycle = 1 ms, with MAX_MS=50 and GAP_MS=4.
- Single request: `req[1]` pulse, player busy for 10 cycles → `trigger[1]` at +2, `active` for 1+1+10 cycles, `sound` mirrors `player_sound[1]`, then 4 silent cycles before IDLE.
- Simultaneous `req`=3'b110 → source 1 granted first; source 2 gets START exactly 4 GAP cycles after source 1's PLAY ends.
- Request during PLAY: `req[0]` arrives while source 2 plays → no preemption; source 0 is served after GAP.
- Timeout: busy held high → forced to GAP after 50 PLAY cycles; `player_enable`=0 from that point.
- Dead player: busy never asserts → GAP after 8 WAIT cycles, no hang; then the next pending request is served.
- Reset during PLAY, and `mute` during a tone → all outputs zero on the next edge and `pend` cleared after reset; with `mute`=1, `sound`=0 while `active` stays 1.

Source files
------------

// File: rtl/tone_arbiter_pkg.sv
// Shared definitions for the speaker arbiter: FSM encoding, dead-player wait limit, timer width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tone_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Cycles a triggered player gets to raise busy before it is treated as dead.
  localparam int WAIT_LIMIT = 8;

  // Width of the single state timer.
  localparam int TIMER_W = 32;

endpackage

// File: rtl/tone_priority_encoder.sv
// Lowest-index-first priority encoder over the pending request vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; valid is low when no bit is set and index is then 0.
//
// Ports:
//   bits  - request vector, bit 0 has the highest priority
//   index - position of the lowest set bit
//   valid - high when any bit is set
module tone_priority_encoder
  import tone_arbiter_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] index,
  output logic         valid
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) begin
        index = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Shares one speaker pin among several tone players: latches play requests, grants by fixed priority, gaps between tones.
// Latency: request edge to player trigger is 2 cycles when idle; sound lags the granted player's wave by 1 cycle.
// Backpressure: no preemption; requests arriving while busy wait in a one-deep pending bit per source.
//
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   mute           - forces sound low without touching arbitration
//   req            - per-source play request, rising edge captured
//   player_busy    - per-source "currently sounding" from the players
//   player_sound   - per-source square waves from the players
//   trigger        - one-cycle start pulse to the granted player
//   player_enable  - one-hot run enable for the granted player
//   grant          - index of the current or most recent grant
//   active         - high from START through PLAY
//   sound          - registered speaker drive
module tone_arbiter
  import tone_arbiter_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int NUM_SOURCES     = 3,
  parameter int MAX_MS          = 3000,
  parameter int GAP_MS          = 20
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           mute,
  input  logic [NUM_SOURCES-1:0]         req,
  input  logic [NUM_SOURCES-1:0]         player_busy,
  input  logic [NUM_SOURCES-1:0]         player_sound,
  output logic [NUM_SOURCES-1:0]         trigger,
  output logic [NUM_SOURCES-1:0]         player_enable,
  output logic [$clog2(NUM_SOURCES)-1:0] grant,
  output logic                           active,
  output logic                           sound
);

  localparam int GW         = $clog2(NUM_SOURCES);
  localparam int CYC_PER_MS = CLOCK_FREQUENCY / 1000;

  // Terminal timer values: each state compares against count-1 because the
  // timer reads 0 in the first cycle after entry.
  localparam logic [TIMER_W-1:0] PLAY_LAST = TIMER_W'(MAX_MS * CYC_PER_MS - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_MS * CYC_PER_MS - 1);
  localparam logic [TIMER_W-1:0] WAIT_LAST = TIMER_W'(WAIT_LIMIT - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [GW-1:0]          grant_nxt;
  logic [NUM_SOURCES-1:0] req_q;
  logic [NUM_SOURCES-1:0] pend;
  logic [NUM_SOURCES-1:0] pend_clr;
  logic [NUM_SOURCES-1:0] rise;
  logic [GW-1:0]          enc_index;
  logic                   enc_valid;
  logic [TIMER_W-1:0]     timer;
  logic                   busy_g;
  logic                   wave_g;

  assign rise   = req & ~req_q;
  assign busy_g = player_busy[grant];
  assign wave_g = player_sound[grant];

  tone_priority_encoder #(
    .N (NUM_SOURCES),
    .W (GW)
  ) u_enc (
    .bits  (pend),
    .index (enc_index),
    .valid (enc_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    trigger       = '0;
    player_enable = '0;
    active        = 1'b0;
    pend_clr      = '0;
    case (state)
      ST_IDLE: begin
        if (enc_valid) begin
          grant_nxt = enc_index;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        trigger[grant]       = 1'b1;
        player_enable[grant] = 1'b1;
        active               = 1'b1;
        pend_clr[grant]      = 1'b1;
        state_nxt            = ST_WAIT;
      end
      ST_WAIT: begin
        // Give the player's ROM a few cycles to start; a silent player is
        // abandoned so one broken source cannot lock up the speaker.
        player_enable[grant] = 1'b1;
        active               = 1'b1;
        if (busy_g) begin
          state_nxt = ST_PLAY;
        end else if (timer == WAIT_LAST) begin
          state_nxt = ST_GAP;
        end
      end
      ST_PLAY: begin
        player_enable[grant] = 1'b1;
        active               = 1'b1;
        if (!busy_g || timer == PLAY_LAST) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant <= '0;
      req_q <= '0;
      pend  <= '0;
      timer <= '0;
      sound <= 1'b0;
    end else begin
      grant <= grant_nxt;
      req_q <= req;
      // A fresh edge landing on the START cycle of the same source re-queues it.
      pend  <= (pend & ~pend_clr) | rise;
      timer <= (state_nxt != state) ? '0 : timer + TIMER_W'(1);
      sound <= wave_g & active & ~mute;
    end
  end

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter at 1 kHz (1 cycle = 1 ms), MAX_MS=50, GAP_MS=4.
// A behavioural player per source raises busy the cycle after its trigger for a programmed length.
// All expected cycle counts below are hand-derived from the arbiter timing.
module tb_tone_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       mute;
  logic [2:0] req;
  logic [2:0] player_busy;
  logic [2:0] player_sound;
  logic [2:0] trigger;
  logic [2:0] player_enable;
  logic [1:0] grant;
  logic       active;
  logic       sound;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   blen [3];
  int   busy_left [3];
  logic kill;
  logic wave;
  logic [2:0] trig_s;

  tone_arbiter #(
    .CLOCK_FREQUENCY (1000),
    .NUM_SOURCES     (3),
    .MAX_MS          (50),
    .GAP_MS          (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mute          (mute),
    .req           (req),
    .player_busy   (player_busy),
    .player_sound  (player_sound),
    .trigger       (trigger),
    .player_enable (player_enable),
    .grant         (grant),
    .active        (active),
    .sound         (sound)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic nxt();
    @(negedge clock);
    cyc++;
  endtask

  // Steps until trigger[i] is seen (bounded); drops req after the first step.
  task automatic wait_trig(input int i, input int budget);
    int n;
    n = 0;
    do begin
      nxt();
      req = '0;
      n++;
    end while (!trigger[i] && n < budget);
  endtask

  // Counts active cycles from the current one; stops on the first inactive cycle.
  task automatic count_active(input int budget, output int na);
    na = 0;
    while (active && na < budget) begin
      na++;
      nxt();
    end
  endtask

  // Behavioural players: busy for blen[i] cycles starting the cycle after trigger[i].
  initial begin
    player_busy  = '0;
    player_sound = '0;
    wave         = 1'b0;
    for (int i = 0; i < 3; i++) busy_left[i] = 0;
    forever begin
      @(negedge clock);
      trig_s = trigger;
      @(posedge clock);
      #1;
      wave = ~wave;
      for (int i = 0; i < 3; i++) begin
        if (kill) busy_left[i] = 0;
        else if (busy_left[i] > 0) busy_left[i]--;
        if (trig_s[i] && blen[i] > 0) busy_left[i] = blen[i];
        player_busy[i]  = (busy_left[i] > 0);
        player_sound[i] = (busy_left[i] > 0) & wave;
      end
    end
  end

  initial begin
    int   k;
    int   t1c;
    int   na;
    logic prev_ps;

    reset = 1'b1;
    mute  = 1'b0;
    req   = '0;
    kill  = 1'b0;
    for (int i = 0; i < 3; i++) blen[i] = 0;

    // Reset values.
    nxt(); nxt();
    chk("rst_trigger", trigger, 0);
    chk("rst_enable", player_enable, 0);
    chk("rst_grant", grant, 0);
    chk("rst_active", active, 0);
    chk("rst_sound", sound, 0);
    reset = 1'b0;
    nxt();

    // Single request on source 1, busy 10 cycles: START + WAIT + 10 PLAY.
    blen[1] = 10;
    req = 3'b010; k = cyc;
    wait_trig(1, 10);
    chk("t1_trig", trigger, 3'b010);
    chk("t1_trig_lat", cyc - k, 2);
    chk("t1_grant", grant, 1);
    prev_ps = 1'b0;
    na = 0;
    while (active && na < 40) begin
      chk("t1_sound", sound, prev_ps);
      chk("t1_enable", player_enable, 3'b010);
      prev_ps = player_sound[1];
      na++;
      nxt();
    end
    chk("t1_active_len", na, 12);
    for (int j = 0; j < 4; j++) begin
      chk("t1_gap_silent", {active, sound, trigger, player_enable}, 0);
      nxt();
    end
    repeat (3) nxt();

    // Simultaneous 3'b110: source 1 first, source 2 after PLAY(3) + GAP(4) + IDLE(1).
    blen[1] = 3; blen[2] = 3;
    req = 3'b110; k = cyc;
    wait_trig(1, 10);
    chk("t2_first_src1", trigger, 3'b010);
    chk("t2_first_lat", cyc - k, 2);
    t1c = cyc;
    wait_trig(2, 30);
    chk("t2_second_src2", trigger, 3'b100);
    chk("t2_second_start", cyc - t1c, 10);
    chk("t2_grant2", grant, 2);
    chk("t2_enable2", player_enable, 3'b100);
    repeat (12) nxt();

    // Request on source 0 while source 2 plays: no preemption.
    blen[2] = 6; blen[0] = 2;
    req = 3'b100;
    wait_trig(2, 10);
    t1c = cyc;
    for (int j = 1; j <= 7; j++) begin
      nxt();
      req = (j == 3) ? 3'b001 : 3'b000;
      chk("t3_no_preempt", {active, trigger, player_enable, grant}, {1'b1, 3'b000, 3'b100, 2'd2});
    end
    wait_trig(0, 20);
    chk("t3_src0_served", trigger, 3'b001);
    chk("t3_src0_after_gap", cyc - t1c, 13);
    repeat (12) nxt();

    // Timeout: busy stays high, PLAY is cut at 50 cycles.
    blen[0] = 200;
    req = 3'b001;
    wait_trig(0, 10);
    count_active(100, na);
    chk("t4_active_len", na, 52);
    chk("t4_enable_off", player_enable, 0);
    kill = 1'b1;
    nxt();
    kill = 1'b0;
    blen[0] = 2;
    repeat (8) nxt();

    // Dead player on source 1, source 2 pending behind it.
    blen[1] = 0; blen[2] = 2;
    req = 3'b110;
    wait_trig(1, 10);
    chk("t5_dead_enable", player_enable, 3'b010);
    t1c = cyc;
    count_active(40, na);
    chk("t5_dead_active_len", na, 9);
    wait_trig(2, 30);
    chk("t5_next_served", trigger, 3'b100);
    chk("t5_next_start", cyc - t1c, 14);
    repeat (12) nxt();

    // Mute mid-tone: sound held low, arbitration unaffected; unmute restores mirroring.
    mute = 1'b1;
    blen[1] = 10;
    req = 3'b010;
    wait_trig(1, 10);
    for (int j = 0; j < 4; j++) begin
      nxt();
      chk("t6_mute_active", active, 1);
      chk("t6_mute_enable", player_enable, 3'b010);
      chk("t6_mute_sound", sound, 0);
    end
    mute = 1'b0;
    prev_ps = player_sound[1];
    nxt();
    chk("t6_unmute_sound", sound, prev_ps);
    prev_ps = player_sound[1];
    nxt();
    chk("t6_unmute_sound2", sound, prev_ps);
    repeat (15) nxt();

    // Reset during PLAY with source 0 pending: everything clears, pend discarded.
    blen[2] = 20; blen[0] = 2;
    req = 3'b100;
    wait_trig(2, 10);
    nxt(); req = 3'b001;
    nxt(); req = 3'b000;
    nxt();
    chk("t7_pre_active", active, 1);
    reset = 1'b1;
    kill  = 1'b1;
    nxt();
    chk("t7_rst_trigger", trigger, 0);
    chk("t7_rst_enable", player_enable, 0);
    chk("t7_rst_grant", grant, 0);
    chk("t7_rst_active", active, 0);
    chk("t7_rst_sound", sound, 0);
    reset = 1'b0;
    kill  = 1'b0;
    for (int j = 0; j < 20; j++) begin
      nxt();
      chk("t7_pend_cleared", {active, trigger}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
